// File: rtl/serial_sync_tx.sv
// serial_sync_tx: serialises each accepted word as a frame of SYNC_PATTERN followed
// by the data word, both MSB first, one bit per clock, with optional idle gap bits.
module serial_sync_tx #(
   parameter int                  SYNC_LEN     = 4,
   parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1001,
   parameter int                  DATA_W       = 8,
   parameter int                  GAP_CYCLES   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int FRAME_W = SYNC_LEN + DATA_W;
   localparam int MAX_A   = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
   localparam int MAX_CNT = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA,
      GAP
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_n;
   logic [FRAME_W-1:0] shift;
   logic [FRAME_W-1:0] shift_n;
   logic               dout_n;
   logic               dout_valid_n;
   logic               data_ready_n;
   logic               busy_n;
   logic               frame_done_n;

   // State, counter, frame shifter and every output are registered here; reset
   // wins over a coincident accept so a word offered during reset is never latched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shift      <= '0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         data_ready <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shift      <= shift_n;
         dout       <= dout_n;
         dout_valid <= dout_valid_n;
         data_ready <= data_ready_n;
         busy       <= busy_n;
         frame_done <= frame_done_n;
      end
   end

   // Next-state logic. The sync pattern and the word are loaded together into one
   // shifter so the serial bit is always its MSB; the counter times each phase.
   // Outputs are decoded from the next state so they appear registered, with the
   // first sync bit on dout in the cycle right after the accept edge.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      shift_n      = shift;
      frame_done_n = 1'b0;

      case (state)
         IDLE: begin
            if (data_valid && data_ready) begin
               state_n = SYNC;
               cnt_n   = SYNC_LAST;
               shift_n = {SYNC_PATTERN, data_in};
            end
         end
         SYNC: begin
            shift_n = shift << 1;
            if (cnt == '0) begin
               state_n = DATA;
               cnt_n   = DATA_LAST;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         DATA: begin
            shift_n = shift << 1;
            if (cnt == '0) begin
               frame_done_n = 1'b1;
               if (GAP_CYCLES > 0) begin
                  state_n = GAP;
                  cnt_n   = GAP_LAST;
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      dout_valid_n = (state_n == SYNC) || (state_n == DATA);
      dout_n       = dout_valid_n & shift_n[FRAME_W-1];
      data_ready_n = (state_n == IDLE);
      busy_n       = (state_n != IDLE);
   end

endmodule

// File: tb/tb_serial_sync_tx.sv
// tb_serial_sync_tx: scoreboard bench. The driver predicts accepts from frame
// timing arithmetic and queues expected bits/frame_done cycles; a monitor pops
// and compares them whenever the transmitter presents output.
module tb_serial_sync_tx;

   localparam int         SYNC_LEN = 4;
   localparam int         DATA_W   = 8;
   localparam int         GAP      = 2;
   localparam int         FRAME    = SYNC_LEN + DATA_W;
   localparam logic [3:0] SYNC     = 4'b1001;

   typedef struct {
      int   cyc;
      logic val;
   } exp_bit_t;

   logic       clk        = 1'b0;
   logic       reset      = 1'b1;
   logic [7:0] data_in    = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready;
   logic       dout;
   logic       dout_valid;
   logic       busy;
   logic       frame_done;

   logic [7:0] din0 = 8'h00;
   logic       dv0  = 1'b0;
   logic       rdy0;
   logic       dout0;
   logic       dvld0;
   logic       busy0;
   logic       fd0;

   int       cyc        = 0;
   int       compared   = 0;
   int       mismatched = 0;
   int       readyAt    = 0;
   int       busyFrom   = 0;
   bit       lastAccept = 1'b0;
   exp_bit_t bitQ[$];
   int       fdQ[$];

   serial_sync_tx #(
      .SYNC_LEN(SYNC_LEN), .SYNC_PATTERN(SYNC), .DATA_W(DATA_W), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .dout(dout), .dout_valid(dout_valid),
      .busy(busy), .frame_done(frame_done)
   );

   serial_sync_tx #(
      .SYNC_LEN(SYNC_LEN), .SYNC_PATTERN(SYNC), .DATA_W(DATA_W), .GAP_CYCLES(0)
   ) dut0 (
      .clk(clk), .reset(reset), .data_in(din0), .data_valid(dv0),
      .data_ready(rdy0), .dout(dout0), .dout_valid(dvld0),
      .busy(busy0), .frame_done(fd0)
   );

   // Free-running clock and an edge counter used as the bench's time base.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One comparison; any difference (including X) is reported and counted.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
      end
   endtask

   // Monitor: pops the expected serial bit whenever dout_valid is seen, and flags
   // bits or frame_done pulses that were due but never showed up.
   always @(negedge clk) begin : monitor
      exp_bit_t e;
      if (cyc >= 1) begin
         if (dout_valid === 1'b1) begin
            if (bitQ.size() == 0) begin
               checkOutput("dout_valid_unexpected", dout_valid, 1'b0);
            end else begin
               e = bitQ.pop_front();
               checkOutput("dout", dout, e.val);
               checkOutput("dout_cycle", cyc, e.cyc);
            end
         end else begin
            checkOutput("dout_idle", dout, 1'b0);
            if (bitQ.size() != 0 && bitQ[0].cyc <= cyc) begin
               checkOutput("dout_valid_missing", dout_valid, 1'b1);
               void'(bitQ.pop_front());
            end
         end
         if (frame_done === 1'b1) begin
            if (fdQ.size() == 0) begin
               checkOutput("frame_done_unexpected", frame_done, 1'b0);
            end else begin
               checkOutput("frame_done_cycle", cyc, fdQ[0]);
               if (fdQ[0] <= cyc) void'(fdQ.pop_front());
            end
         end else if (fdQ.size() != 0 && fdQ[0] <= cyc) begin
            checkOutput("frame_done_missing", frame_done, 1'b1);
            void'(fdQ.pop_front());
         end
      end
   end

   // One bus cycle: check ready/busy against the timing model, drive the inputs
   // for the coming edge, and update the model (reset flushes the in-flight frame).
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
      int       n;
      exp_bit_t e;
      logic [3:0] syncBits;
      logic [7:0] word;
      @(negedge clk);
      #1;
      if (cyc >= 1) begin
         checkOutput("data_ready", data_ready, cyc >= readyAt);
         checkOutput("busy", busy, (cyc >= busyFrom) && (cyc < readyAt));
      end
      data_valid = v;
      data_in    = d;
      reset      = r;
      lastAccept = 1'b0;
      if (r) begin
         while (bitQ.size() != 0 && bitQ[$].cyc > cyc) void'(bitQ.pop_back());
         while (fdQ.size() != 0 && fdQ[$] > cyc) void'(fdQ.pop_back());
         readyAt  = cyc + 1;
         busyFrom = cyc + 1;
      end else if (v && cyc >= readyAt) begin
         n        = cyc + 1;
         syncBits = SYNC;
         word     = d;
         for (int i = 0; i < SYNC_LEN; i++) begin
            e.cyc = n + i;
            e.val = syncBits[SYNC_LEN-1-i];
            bitQ.push_back(e);
         end
         for (int i = 0; i < DATA_W; i++) begin
            e.cyc = n + SYNC_LEN + i;
            e.val = word[DATA_W-1-i];
            bitQ.push_back(e);
         end
         fdQ.push_back(n + FRAME);
         busyFrom   = n;
         readyAt    = n + FRAME + GAP;
         lastAccept = 1'b1;
      end
   endtask

   // Holds data_valid with a word until the model predicts it is accepted.
   task automatic sendWord(input logic [7:0] d);
      int tries = 0;
      do begin
         applyStimulus(1'b1, d, 1'b0);
         tries++;
      end while (!lastAccept && tries < 100);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
   endtask

   initial begin : driver
      int         n0;
      int         pos;
      int         detCount;
      logic       expV;
      logic [3:0] hist;
      logic [11:0] frame0;

      $display("[TB] start");
      // Reset held two cycles with a word offered: nothing may be accepted.
      applyStimulus(1'b1, 8'hC3, 1'b1);
      applyStimulus(1'b1, 8'hC3, 1'b1);
      idle(2);

      // Single frame, then back-to-back frames with data_valid held high.
      sendWord(8'hA5);
      idle(16);
      sendWord(8'h3C);
      sendWord(8'hFF);
      idle(16);

      // Input changes and a stray valid pulse during a frame are ignored.
      sendWord(8'h5A);
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      idle(14);

      // Reset on the 6th bit of a frame aborts it; the next frame is complete.
      sendWord(8'hF0);
      idle(5);
      applyStimulus(1'b0, 8'h00, 1'b1);
      idle(1);
      sendWord(8'h81);
      idle(16);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 79) == 0);
      end

      // Drain outstanding expectations (bounded).
      for (int i = 0; i < 40 && (bitQ.size() != 0 || fdQ.size() != 0); i++) idle(1);
      checkOutput("drain_bits", bitQ.size(), 0);
      checkOutput("drain_frame_done", fdQ.size(), 0);

      // Zero-gap instance: back-to-back 00 words feeding a 1001 detector.
      dv0      = 1'b1;
      din0     = 8'h00;
      n0       = cyc + 1;
      frame0   = {SYNC, 8'h00};
      hist     = 4'b0000;
      detCount = 0;
      for (int k = 0; k < 26; k++) begin
         @(negedge clk);
         #1;
         pos  = (cyc - n0) % (FRAME + 1);
         expV = (pos < FRAME);
         checkOutput("gap0_dout_valid", dvld0, expV);
         checkOutput("gap0_dout", dout0, expV ? frame0[FRAME-1-pos] : 1'b0);
         checkOutput("gap0_frame_done", fd0, pos == FRAME);
         checkOutput("gap0_data_ready", rdy0, pos == FRAME);
         if (dvld0 === 1'b1) begin
            hist = {hist[2:0], dout0};
            if (hist == 4'b1001) begin
               detCount++;
               hist = 4'b0000;
            end
         end
         if (pos == FRAME) checkOutput("gap0_detect_count", detCount, (cyc - n0 + 1) / (FRAME + 1));
      end
      dv0 = 1'b0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_sync_tx.md
Name: serial_sync_tx

Overview:
- Moore-style serial frame transmitter; the transmit end of the team's serial sequence-detector link.
- Accepts a parallel data word over a valid/ready handshake.
- Emits one frame per word, one bit per clock on dout: a fixed sync pattern (default 1001) followed by the data word, both MSB first.
- Drives the detector-side din input in loopback and system benches.

Parameters:
SYNC_PATTERN, 4'b1001, sync bits sent before every data word, MSB first
SYNC_LEN, 4, width of SYNC_PATTERN in bits (>=1)
DATA_W, 8, data word width in bits (>=1)
GAP_CYCLES, 2, idle bit-times inserted after each frame (>=0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_in  input  DATA_W  word to transmit; sampled only on accept
data_valid  input  1  producer has a word on data_in
data_ready  output  1  transmitter can accept a word this cycle
dout  output  1  serial bit stream
dout_valid  output  1  dout carries a frame bit (sync or data)
busy  output  1  frame or gap in progress
frame_done  output  1  one-cycle pulse after the last data bit

Behaviour:
- Single clock; reset is synchronous and active-high. All outputs are registered Moore outputs, decoded from state/counter/shift registers only; no combinational path from inputs to outputs.
- Reset values: state=IDLE, dout=0, dout_valid=0, data_ready=1, busy=0, frame_done=0, counters=0.
- States: IDLE, SYNC, DATA, GAP.
- IDLE:
  - data_ready=1, busy=0, dout=0, dout_valid=0.
  - Accept occurs when data_valid&&data_ready at a rising edge: latch data_in into the shift register, set bit counter=SYNC_LEN-1, go to SYNC.
- SYNC:
  - dout=SYNC_PATTERN[cnt], dout_valid=1, busy=1, data_ready=0.
  - Lasts SYNC_LEN cycles, then go to DATA with cnt=DATA_W-1.
- DATA:
  - dout=shift[DATA_W-1] (MSB first), dout_valid=1; shift left one bit per cycle.
  - Lasts DATA_W cycles.
  - After the last bit: go to GAP with cnt=GAP_CYCLES-1, or go straight to IDLE when GAP_CYCLES=0.
- GAP: dout=0, dout_valid=0, busy=1, data_ready=0 for GAP_CYCLES cycles, then IDLE.
- frame_done:
  - High for exactly one cycle: the first cycle after the last data bit (first GAP cycle, or the IDLE cycle when GAP_CYCLES=0).
  - Never asserted for an aborted frame.
- Latency: accept at edge E puts the first sync bit on dout in the cycle after E. A frame occupies SYNC_LEN+DATA_W consecutive valid cycles with no bubbles.
- Throughput: one frame per SYNC_LEN+DATA_W+GAP_CYCLES+1 cycles. The minimum single IDLE cycle is where data_ready=1.
- Handshake:
  - data_valid while data_ready=0 is ignored, and data_in changes have no effect on the frame in flight.
  - The producer holds data_valid/data_in until accepted.
  - data_ready never rises while busy=1.
- dout=0 whenever dout_valid=0; no X on any output after the first reset edge.
- Reset mid-operation (any state): abort at that edge; the following cycle shows reset values. The partial frame is dropped and no frame_done is issued.
- reset coincident with accept: reset wins and the word is not latched.
- Counters are sized to max(SYNC_LEN,DATA_W,GAP_CYCLES) with no wrap-around.
- No data scrambling or stuffing: a data word containing the sync pattern is sent verbatim.

Test Plan:
1. Reset held 2 cycles, data_valid=1 -> dout=0, dout_valid=0, data_ready=1, busy=0, frame_done=0; no accept during reset.
2. Single accept of 8'hA5 at edge E0 -> cycles 1-12 dout=1,0,0,1,1,0,1,0,0,1,0,1 with dout_valid=1; frame_done=1 only in cycle 13; cycles 13-14 dout_valid=0, busy=1; cycle 15 data_ready=1, busy=0.
3. data_valid held high with 8'h3C then 8'hFF -> 8'h3C's frame, 2 gap cycles, 1 ready cycle, then 8'hFF's frame (1001_00111100, gap, 1001_11111111); exactly two frame_done pulses 15 cycles apart.
4. During an 8'h5A frame, toggle data_in to 8'h00 and pulse data_valid -> transmitted bits remain 1001_01011010; no second frame starts before data_ready=1.
5. reset asserted on the 6th valid bit of frame 8'hF0 -> next cycle dout_valid=0, data_ready=1, no frame_done; a subsequent 8'h81 accept produces a complete, correct frame.
6. GAP_CYCLES=0 build, back-to-back words 8'h00,8'h00 looped into the 1001 non-overlapping Moore detector -> each frame 1001_00000000; frame_done in the IDLE cycle after each last bit; detector flags the sync exactly once per frame.
